// File: rtl/uart_rx.sv
// 16x-oversampling UART receiver: 8 data bits LSB-first, mid-bit sampling, stop-bit/break detection.
// Define UART_RX_PARITY_EN to add a parity bit (even/odd via PARITY_MODE); default build is 8N1.
module uart_rx #(
  parameter int CLK_FREQ  = 125_000_000,
  parameter int BAUD_RATE = 9600
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RXD,
  input  logic       PARITY_MODE,
  output logic [7:0] DOUT,
  output logic       VALID,
  output logic       PARITY_ERR,
  output logic       FRAME_ERR,
  output logic       BUSY
);

  localparam int DIV_RAW = CLK_FREQ / (BAUD_RATE * 16);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;
`endif

  // Parity check: XOR of data and parity bit must equal the selected mode (0 even, 1 odd).
  function automatic logic parity_fail(input logic [7:0] data, input logic par_bit,
                                       input logic odd_mode);
    return ((^data) ^ par_bit) != odd_mode;
  endfunction

  // Stage p0/p1: two-flop synchronizer, reset to the idle (high) line level.
  logic rxd_p0;
  logic rxd_s;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rxd_p0 <= 1'b1;
      rxd_s  <= 1'b1;
    end else begin
      rxd_p0 <= RXD;
      rxd_s  <= rxd_p0;
    end
  end

  // Oversample divider: free-running, realigned to the start edge.
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic             div_clr;

  assign tick = (div_cnt == DIV_LAST);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      div_cnt <= '0;
    end else if (div_clr || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  state_t     state, state_n;
  logic [3:0] tc, tc_n;
  logic [2:0] bi, bi_n;
  logic       armed, armed_n;
  logic       sample_en;
  logic       frame_done;
  logic [7:0] shreg;
  logic [7:0] dout_q;
  logic       valid_q;
  logic       frame_err_q;

`ifdef UART_RX_PARITY_EN
  logic perr_pend, perr_pend_n;
  logic parity_err_q;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= S_IDLE;
      tc    <= '0;
      bi    <= '0;
      armed <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_pend <= 1'b0;
`endif
    end else begin
      state <= state_n;
      tc    <= tc_n;
      bi    <= bi_n;
      armed <= armed_n;
`ifdef UART_RX_PARITY_EN
      perr_pend <= perr_pend_n;
`endif
    end
  end

  // armed blocks a held-low (break) line from retriggering until it has been seen idle.
  always_comb begin
    state_n    = state;
    tc_n       = tc;
    bi_n       = bi;
    armed_n    = armed;
    div_clr    = 1'b0;
    sample_en  = 1'b0;
    frame_done = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_pend_n = perr_pend;
`endif
    case (state)
      S_IDLE: begin
        if (rxd_s) begin
          armed_n = 1'b1;
        end else if (armed) begin
          state_n = S_START;
          tc_n    = '0;
          div_clr = 1'b1;
          armed_n = 1'b0;
        end
      end
      S_START: begin
        if (tick) begin
          if (tc == 4'd7) begin
            if (!rxd_s) begin
              state_n = S_DATA;
              tc_n    = '0;
              bi_n    = '0;
            end else begin
              state_n = S_IDLE;
            end
          end else begin
            tc_n = tc + 4'd1;
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          if (tc == 4'd15) begin
            tc_n      = '0;
            sample_en = 1'b1;
            if (bi == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_n = S_PARITY;
`else
              state_n = S_STOP;
`endif
            end else begin
              bi_n = bi + 3'd1;
            end
          end else begin
            tc_n = tc + 4'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (tick) begin
          if (tc == 4'd15) begin
            tc_n        = '0;
            perr_pend_n = parity_fail(shreg, rxd_s, PARITY_MODE);
            state_n     = S_STOP;
          end else begin
            tc_n = tc + 4'd1;
          end
        end
      end
`endif
      S_STOP: begin
        if (tick) begin
          if (tc == 4'd15) begin
            tc_n       = '0;
            frame_done = 1'b1;
            state_n    = S_IDLE;
          end else begin
            tc_n = tc + 4'd1;
          end
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // Data bits land directly in their final position; no reset needed since all 8 are rewritten per frame.
  always_ff @(posedge CLK) begin
    if (sample_en) begin
      shreg[bi] <= rxd_s;
    end
  end

  // Stage p2: output register, updated only in the VALID cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      dout_q      <= 8'h00;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      valid_q <= frame_done;
      if (frame_done) begin
        dout_q      <= shreg;
        frame_err_q <= !rxd_s;
`ifdef UART_RX_PARITY_EN
        parity_err_q <= perr_pend;
`endif
      end
    end
  end

  assign DOUT      = dout_q;
  assign VALID     = valid_q;
  assign FRAME_ERR = frame_err_q;
  assign BUSY      = (state != S_IDLE);

`ifdef UART_RX_PARITY_EN
  assign PARITY_ERR = parity_err_q;
`else
  logic unused_parity_mode;
  assign unused_parity_mode = PARITY_MODE;
  assign PARITY_ERR = 1'b0;
`endif

endmodule
